// File: rtl/ahb_checked_responder_pkg.sv
// Shared definitions for the checksummed AHB responder: bus encodings, FSM states
// and the (39,32) Hamming SECDED check-bit generator also used by the core bus logic.
package ahb_checked_responder_pkg;

   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_ERR1,
      ST_ERR2
   } ahbState_e;

   // Data bits occupy the non-power-of-two codeword positions 3,5,6,7,9..38; each
   // Hamming check bit is the XOR of the positions of the set data bits, and bit 6
   // is overall parity across data and the six Hamming bits.
   function automatic logic [6:0] checksum(input logic [31:0] data);
      logic [6:0]  chk;
      logic [31:0] rest;
      logic [5:0]  pos;
      chk  = '0;
      rest = data;
      pos  = 6'd1;
      for (int n = 0; n < 38; n++) begin
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            if (rest[0]) begin
               chk[5:0] = chk[5:0] ^ pos;
            end
            rest = rest >> 1;
         end
         pos = pos + 6'd1;
      end
      chk[6] = (^data) ^ (^chk[5:0]);
      return chk;
   endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Single-port synchronous SRAM, 32-bit words with byte enables, one-cycle read
// latency. The read register only changes on a read, so it holds between reads.
module ahb_sram_array #(
   parameter int WORDS  = 1024,
   parameter int ADDR_W = $clog2(WORDS)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            if (be_i[0]) mem_q[addr_i][7:0]   <= wdata_i[7:0];
            if (be_i[1]) mem_q[addr_i][15:8]  <= wdata_i[15:8];
            if (be_i[2]) mem_q[addr_i][23:16] <= wdata_i[23:16];
            if (be_i[3]) mem_q[addr_i][31:24] <= wdata_i[31:24];
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_checked_responder.sv
// AHB-Lite slave serving a local SRAM with a 7-bit checksum sideband: reads carry a
// generated checksum, writes with a bad checksum are dropped and answered with ERROR.
module ahb_checked_responder
   import ahb_checked_responder_pkg::*;
#(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_hsel_i,
   input  logic [31:0] s_haddr_i,
   input  logic [1:0]  s_htrans_i,
   input  logic        s_hwrite_i,
   input  logic [2:0]  s_hsize_i,
   input  logic [2:0]  s_hburst_i,
   input  logic [3:0]  s_hprot_i,
   input  logic        s_hmastlock_i,
   input  logic        s_hreadyin_i,
   input  logic [31:0] s_hwdata_i,
   input  logic [6:0]  s_hwchecksum_i,
   output logic [31:0] s_hrdata_o,
   output logic [6:0]  s_hrchecksum_o,
   output logic        s_hreadyout_o,
   output logic        s_hresp_o,
   output logic [7:0]  s_err_cnt_o
);

   localparam int          WORD_AW   = $clog2(MEM_WORDS);
   localparam int          OFFS_W    = WORD_AW + 2;
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
   localparam logic [1:0]  WAIT_CNT  = 2'(WAIT_STATES);
   localparam logic [1:0]  DEFER_CNT = (WAIT_STATES > 0) ? 2'(WAIT_STATES) : 2'd1;

   ahbState_e         state_q, state_d;
   logic [1:0]        waitCnt_q, waitCnt_d;
   logic [OFFS_W-1:0] offs_q, offs_d;
   logic [1:0]        size_q, size_d;
   logic              rdDefer_q, rdDefer_d;
   logic [7:0]        errCnt_q, errCnt_d;
   logic [31:0]       hrdata_q, hrdata_d;

   logic [31:0]        offset;
   logic               transReq;
   logic               addrErr;
   logic               chkOk;
   logic               readyOut;
   logic               respErr;
   logic               acceptNow;
   logic               wrCommit;
   logic               rdIssue;
   logic               rdDone;
   logic               sramEn;
   logic               sramWe;
   logic [3:0]         sramBe;
   logic [WORD_AW-1:0] sramAddr;
   logic [31:0]        sramRdata;
   logic               unusedSigs;

   assign unusedSigs = ^{s_hburst_i, s_hprot_i, s_hmastlock_i};

   assign offset   = s_haddr_i - BASE_ADDR;
   assign transReq = s_hsel_i & s_hreadyin_i &
                     ((s_htrans_i == HTRANS_NONSEQ) | (s_htrans_i == HTRANS_SEQ));
   assign addrErr  = (s_hsize_i > HSIZE_WORD) |
                     ((s_hsize_i == HSIZE_HALF) & s_haddr_i[0]) |
                     ((s_hsize_i == HSIZE_WORD) & (s_haddr_i[1:0] != 2'b00)) |
                     ({1'b0, offset} >= MEM_BYTES);
   assign chkOk    = (checksum(s_hwdata_i) == s_hwchecksum_i);

   // Bus handshake seen by the master; a faulted write holds HREADY low in its last
   // cycle so the pending address phase is not consumed before the ERROR pair.
   always_comb begin
      readyOut = 1'b1;
      respErr  = 1'b0;
      unique case (state_q)
         ST_RD:   readyOut = (waitCnt_q == 2'd0);
         ST_WR:   readyOut = (waitCnt_q == 2'd0) & chkOk;
         ST_ERR1: begin
            readyOut = 1'b0;
            respErr  = 1'b1;
         end
         ST_ERR2: respErr = 1'b1;
         default: ;
      endcase
   end

   assign acceptNow = transReq & readyOut;
   assign wrCommit  = (state_q == ST_WR) & (waitCnt_q == 2'd0) & chkOk & ~s_reset_i;
   assign rdIssue   = acceptNow & ~addrErr & ~s_hwrite_i & ~wrCommit;
   assign rdDone    = (state_q == ST_RD) & (waitCnt_q == 2'd0);

   // Next-state: finish the current data phase, then let an accepted address phase
   // override the destination (only possible in a cycle where HREADY is high).
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      offs_d    = offs_q;
      size_d    = size_q;
      rdDefer_d = 1'b0;
      unique case (state_q)
         ST_RD: begin
            if (waitCnt_q != 2'd0) waitCnt_d = waitCnt_q - 2'd1;
            else                   state_d   = ST_IDLE;
         end
         ST_WR: begin
            if (waitCnt_q != 2'd0) waitCnt_d = waitCnt_q - 2'd1;
            else if (chkOk)        state_d   = ST_IDLE;
            else                   state_d   = ST_ERR1;
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = ST_IDLE;
         default: ;
      endcase
      if (acceptNow) begin
         offs_d = offset[OFFS_W-1:0];
         size_d = s_hsize_i[1:0];
         if (addrErr) begin
            state_d = ST_ERR1;
         end else if (s_hwrite_i) begin
            state_d   = ST_WR;
            waitCnt_d = WAIT_CNT;
         end else begin
            state_d   = ST_RD;
            rdDefer_d = wrCommit;
            waitCnt_d = wrCommit ? DEFER_CNT : WAIT_CNT;
         end
      end
   end

   always_comb begin
      errCnt_d = errCnt_q;
      if ((state_d == ST_ERR1) && (state_q != ST_ERR1) && (errCnt_q != 8'hFF)) begin
         errCnt_d = errCnt_q + 8'd1;
      end
   end

   always_comb begin
      if (size_q == 2'b00)      sramBe = 4'b0001 << offs_q[1:0];
      else if (size_q == 2'b01) sramBe = offs_q[1] ? 4'b1100 : 4'b0011;
      else                      sramBe = 4'b1111;
   end

   // The SRAM port serves the committing write first; a read that lost the port
   // to it is issued from the captured offset in its first data-phase cycle.
   assign sramEn   = wrCommit | rdIssue | rdDefer_q;
   assign sramWe   = wrCommit;
   assign sramAddr = (wrCommit | rdDefer_q) ? offs_q[OFFS_W-1:2] : offset[OFFS_W-1:2];

   assign hrdata_d = rdDone ? sramRdata : hrdata_q;

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q   <= ST_IDLE;
         waitCnt_q <= 2'd0;
         offs_q    <= '0;
         size_q    <= 2'd0;
         rdDefer_q <= 1'b0;
         errCnt_q  <= 8'd0;
         hrdata_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         offs_q    <= offs_d;
         size_q    <= size_d;
         rdDefer_q <= rdDefer_d;
         errCnt_q  <= errCnt_d;
         hrdata_q  <= hrdata_d;
      end
   end

   ahb_sram_array #(
      .WORDS  (MEM_WORDS),
      .ADDR_W (WORD_AW)
   ) u_sram (
      .clk_i   (s_clk_i),
      .en_i    (sramEn),
      .we_i    (sramWe),
      .be_i    (sramBe),
      .addr_i  (sramAddr),
      .wdata_i (s_hwdata_i),
      .rdata_o (sramRdata)
   );

   assign s_hrdata_o     = hrdata_d;
   assign s_hrchecksum_o = checksum(hrdata_d);
   assign s_hreadyout_o  = readyOut;
   assign s_hresp_o      = respErr;
   assign s_err_cnt_o    = errCnt_q;

endmodule
